// File: rtl/cache_controller_pkg.sv
// Shared constants and types for the cache controller slice.
//   WORD_LENGTH  - width of one cached/memory data word
//   SETS         - number of direct-mapped lines (4 words each)
//   TAG_WIDTH    - address bits above the index
//   INDEX_WIDTH  - line-select bits
//   OFFSET_WIDTH - word-within-line bits
//   WAIT_WIDTH   - memory latency counter width (MEM_LATENCY <= 15)
//   state_t      - controller FSM encoding
//   line_t       - one full cache line, word 0 in element [0]
package cache_controller_pkg;

  localparam int WORD_LENGTH  = 16;
  localparam int SETS         = 1024;
  localparam int TAG_WIDTH    = 3;
  localparam int INDEX_WIDTH  = 10;
  localparam int OFFSET_WIDTH = 2;
  localparam int WORDS        = 4;
  localparam int WAIT_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FILL    = 2'd2
  } state_t;

  typedef logic [WORD_LENGTH-1:0]            word_t;
  typedef logic [WORDS-1:0][WORD_LENGTH-1:0] line_t;

endpackage

// File: rtl/cache_controller_if.sv
// CPU request / main-memory bus bundle for cache_controller.
//   master modport: CPU + memory side (drives requests and block words)
//   slave  modport: the controller
// Signals:
//   req_valid, req_address   - CPU read request
//   req_ready                - controller idle and accepting
//   data_out, data_valid     - read data and its one-cycle strobe
//   mem_address, hit         - block address / last tag result to memory
//   mem_data1..mem_data4     - block words at offsets 0..3 from memory
//   hit_count, access_count  - statistics counters
interface cache_controller_if #(
  parameter int ADDR_WIDTH = 15
);
  import cache_controller_pkg::*;

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_address;
  logic                  req_ready;
  word_t                 data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  hit;
  word_t                 mem_data1;
  word_t                 mem_data2;
  word_t                 mem_data3;
  word_t                 mem_data4;
  logic [15:0]           hit_count;
  logic [15:0]           access_count;

  modport master (
    output req_valid, req_address, mem_data1, mem_data2, mem_data3, mem_data4,
    input  req_ready, data_out, data_valid, mem_address, hit,
           hit_count, access_count
  );

  modport slave (
    input  req_valid, req_address, mem_data1, mem_data2, mem_data3, mem_data4,
    output req_ready, data_out, data_valid, mem_address, hit,
           hit_count, access_count
  );

endinterface

// File: rtl/cache_controller_array.sv
// Direct-mapped line storage: data words, tags and valid bits.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (valid bits only)
//   i_rd_index    - line to read (combinational read port)
//   o_rd_line     - all four words of that line
//   o_rd_tag      - stored tag of that line
//   o_rd_valid    - valid bit of that line
//   i_wr_en       - write a whole line this edge
//   i_wr_index    - line to write
//   i_wr_tag      - tag stored with the new line
//   i_wr_line     - four words of the new line
module cache_controller_array
  import cache_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] i_rd_index,
  output line_t                  o_rd_line,
  output logic [TAG_WIDTH-1:0]   o_rd_tag,
  output logic                   o_rd_valid,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  line_t                  i_wr_line
);

  line_t                r_data [SETS];
  logic [TAG_WIDTH-1:0] r_tag  [SETS];
  logic [SETS-1:0]      r_valid;

  // Data and tags are meaningless until their valid bit is set, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_index] <= i_wr_line;
      r_tag[i_wr_index]  <= i_wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  assign o_rd_line  = r_data[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_valid = r_valid[i_rd_index];

endmodule

// File: rtl/cache_controller.sv
// Read-only direct-mapped cache controller (1024 lines x 4 words).
// Optional statistics counters are built only when CACHE_STATS_EN is
// defined; otherwise hit_count/access_count read as zero.
// Parameters:
//   MEM_LATENCY - cycles mem_address is held before the block is sampled (1..15)
//   ADDR_WIDTH  - word address width shared with main memory
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - cache_controller_if.slave (request, response, memory, stats)
//
// state   | meaning
// IDLE    | req_ready high, waiting for req_valid
// COMPARE | tag lookup of latched address; hit answers, miss starts fill
// FILL    | memory block address held, counting MEM_LATENCY cycles
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_WIDTH  = 15
) (
  input logic               clk,
  input logic               rst,
  cache_controller_if.slave bus
);

  localparam logic [WAIT_WIDTH-1:0] LAT_TC = WAIT_WIDTH'(MEM_LATENCY - 1);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [WAIT_WIDTH-1:0]   r_wait;
  word_t                   r_data_out;
  logic                    r_data_valid;
  logic                    r_hit;
  logic [ADDR_WIDTH-1:0]   r_mem_address;

  logic [OFFSET_WIDTH-1:0] w_off;
  logic [INDEX_WIDTH-1:0]  w_index;
  logic [TAG_WIDTH-1:0]    w_tag;
  line_t                   w_rd_line;
  logic [TAG_WIDTH-1:0]    w_rd_tag;
  logic                    w_rd_valid;
  logic                    w_lookup_hit;
  logic                    w_fill_done;
  line_t                   w_fill_line;

  assign w_off   = r_addr[OFFSET_WIDTH-1:0];
  assign w_index = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_tag   = r_addr[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];

  assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);

  // Gating with rst keeps a fill interrupted by reset from landing in the array.
  assign w_fill_done = (r_state == FILL) && (r_wait == LAT_TC) && !rst;
  assign w_fill_line = {bus.mem_data4, bus.mem_data3, bus.mem_data2, bus.mem_data1};

  cache_controller_array u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_index),
    .o_rd_line  (w_rd_line),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .i_wr_en    (w_fill_done),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_line  (w_fill_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wait        <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_hit         <= 1'b0;
      r_mem_address <= '0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_address;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          r_hit <= w_lookup_hit;
          if (w_lookup_hit) begin
            r_data_out   <= w_rd_line[w_off];
            r_data_valid <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_mem_address <= {r_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            r_wait        <= '0;
            r_state       <= FILL;
          end
        end
        FILL: begin
          r_wait <= r_wait + 1'b1;
          if (w_fill_done) begin
            r_data_out   <= w_fill_line[w_off];
            r_data_valid <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_data_valid;
  assign bus.hit         = r_hit;
  assign bus.mem_address = r_mem_address;

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_access_count;

  // Both counters saturate rather than wrap so a long run never reports
  // a misleadingly small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count    <= '0;
      r_access_count <= '0;
    end else if (r_state == COMPARE) begin
      if (r_access_count != 16'hFFFF) r_access_count <= r_access_count + 16'd1;
      if (w_lookup_hit && (r_hit_count != 16'hFFFF)) r_hit_count <= r_hit_count + 16'd1;
    end
  end

  assign bus.hit_count    = r_hit_count;
  assign bus.access_count = r_access_count;
`else
  assign bus.hit_count    = '0;
  assign bus.access_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller. Main memory is modelled
// as data(word address) = address - 1024, so expected read data is derived
// from the request address alone.
module tb_cache_controller;
  import cache_controller_pkg::*;

  localparam int ML = 2;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        hit;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [14:0] exp_mem = '0;
  int   exp_acc  = 0;
  int   exp_hits = 0;

  cache_controller_if #(.ADDR_WIDTH(15)) bus ();

  cache_controller #(.MEM_LATENCY(ML), .ADDR_WIDTH(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.mem_data1 = 16'({1'b0, bus.mem_address}) - 16'd1024;
    bus.mem_data2 = 16'({1'b0, bus.mem_address}) - 16'd1023;
    bus.mem_data3 = 16'({1'b0, bus.mem_address}) - 16'd1022;
    bus.mem_data4 = 16'({1'b0, bus.mem_address}) - 16'd1021;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [14:0] a, input bit h);
    exp_t e;
    e.addr = a;
    e.data = 16'({1'b0, a}) - 16'd1024;
    e.hit  = h;
    e.lat  = h ? 2 : 2 + ML;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.req_ready, 1);
  endtask

  task automatic wait_dv(input int start, output int n);
    n = start;
    while (bus.data_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("dv_wait", bus.data_valid, 1);
  endtask

  // Called at the negedge where data_valid is high; leaves one negedge later.
  task automatic check_pop(input int lat);
    exp_t e;
    check("sb_nonempty", 32'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    if (!e.hit) exp_mem = {e.addr[14:2], 2'b00};
    exp_acc++;
    if (e.hit) exp_hits++;
    check("data_out", bus.data_out, e.data);
    check("hit", bus.hit, e.hit);
    check("latency", lat, e.lat);
    check("mem_address", bus.mem_address, exp_mem);
    check("access_count", bus.access_count, STATS ? exp_acc : 0);
    check("hit_count", bus.hit_count, STATS ? exp_hits : 0);
    @(negedge clk);
    check("dv_pulse", bus.data_valid, 0);
    check("data_hold", bus.data_out, e.data);
  endtask

  task automatic do_read(input logic [14:0] a, input bit h);
    int n;
    wait_ready();
    bus.req_valid   = 1'b1;
    bus.req_address = a;
    push_exp(a, h);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_dv(1, n);
    check_pop(n);
  endtask

  initial begin
    int n;
    int seen;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_address = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", bus.req_ready, 1);
    check("rst_data_out", bus.data_out, 0);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_access_count", bus.access_count, 0);
    check("rst_hit_count", bus.hit_count, 0);

    // cold miss, then hits on the rest of the line
    do_read(15'd1024, 1'b0);
    do_read(15'd1025, 1'b1);
    do_read(15'd1026, 1'b1);
    do_read(15'd1027, 1'b1);

    // conflicting tag on index 256 evicts, then original tag misses again
    do_read(15'd5120, 1'b0);
    do_read(15'd1024, 1'b0);

    // request held during a fill is ignored until IDLE, then taken back-to-back
    wait_ready();
    bus.req_valid   = 1'b1;
    bus.req_address = 15'd1028;
    push_exp(15'd1028, 1'b0);
    @(negedge clk);
    bus.req_address = 15'd1030;
    n = 1;
    while (bus.data_valid !== 1'b1 && n < 64) begin
      check("busy_ready", bus.req_ready, 0);
      @(negedge clk);
      n++;
    end
    check("dv_wait", bus.data_valid, 1);
    check("b2b_ready", bus.req_ready, 1);
    push_exp(15'd1030, 1'b1);
    check_pop(n);
    bus.req_valid = 1'b0;
    wait_dv(1, n);
    check_pop(n);

    // reset in the middle of a fill aborts it
    wait_ready();
    bus.req_valid   = 1'b1;
    bus.req_address = 15'd2048;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("fill_busy", bus.req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_mem  = '0;
    exp_acc  = 0;
    exp_hits = 0;
    check("abort_ready", bus.req_ready, 1);
    check("abort_data_out", bus.data_out, 0);
    check("abort_mem_address", bus.mem_address, 0);
    check("abort_hit", bus.hit, 0);
    seen = 0;
    repeat (8) begin
      if (bus.data_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort_no_dv", seen, 0);
    do_read(15'd2048, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter MEM_LATENCY, default 2, meaning: number of clk cycles the controller holds mem_address stable before sampling the memory block (legal range 1..15).
REQ-002 Parameter ADDR_WIDTH, default 15, meaning: word-address width shared with main memory.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU read request strobe.
REQ-006 req_address  input  15  CPU word address.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 data_out  output  WORD_LENGTH  read data.
REQ-009 data_valid  output  1  data_out is valid; one-cycle pulse per request.
REQ-010 mem_address  output  15  block address to main memory, offset bits forced 2'b00.
REQ-011 hit  output  1  result of last tag compare, fed to main memory.
REQ-012 mem_data1..mem_data4  input  WORD_LENGTH each  block words at offsets 0..3 from main memory.
REQ-013 hit_count, access_count  output  16 each  statistics counters.

Function
REQ-014 The cache SHALL be direct-mapped, `SETS (1024) lines of 4 words; offset = addr[1:0], index = addr[11:2], tag = addr[14:12]; one valid bit per line.
REQ-015 The FSM SHALL have states IDLE, COMPARE, FILL; req_ready = 1 only in IDLE.
REQ-016 IDLE: on req_valid, latch req_address and go to COMPARE; otherwise remain in IDLE.
REQ-017 COMPARE, hit (valid & tag match): register hit=1, data_out=stored word at offset, data_valid=1, go to IDLE; data_valid is high in the cycle after the second edge following acceptance.
REQ-018 COMPARE, miss: register hit=0, drive mem_address={addr[14:2],2'b00}, clear wait counter, go to FILL.
REQ-019 FILL: increment wait counter each edge; on the edge where counter == MEM_LATENCY-1, write mem_data1..4 into the line, set tag and valid, output the word selected by offset on data_out, pulse data_valid, go to IDLE.
REQ-020 Miss latency: data_valid SHALL appear MEM_LATENCY cycles after a hit would have.
REQ-021 req_valid while req_ready=0 SHALL be ignored and not queued.
REQ-022 mem_address SHALL hold its value outside FILL; data_out SHALL hold its last value when data_valid=0.
REQ-023 A conflicting tag in the same index SHALL overwrite the whole line (no write-back; read-only cache).
REQ-024 Back-to-back requests SHALL be accepted in the cycle data_valid is high (FSM already in IDLE).

Reset
REQ-025 rst SHALL force state=IDLE, all valid bits=0, data_out=0, data_valid=0, hit=0, mem_address=0, wait counter=0, both counters=0.
REQ-026 rst during FILL SHALL abort the fill: no line written, no data_valid pulse.
REQ-027 Data/tag storage SHALL NOT require reset; only valid bits do.

Configuration
REQ-028 Macro CACHE_STATS_EN: when defined, access_count increments once per COMPARE and hit_count once per COMPARE hit, both saturating at 16'hFFFF; when undefined, counters and their logic are omitted and both outputs are tied to 0.

Structure
REQ-029 WORD_LENGTH, SETS, TAG_WIDTH (3), INDEX_WIDTH (10) and FSM state encodings SHALL live in the shared constants.vh.
REQ-030 Storage (data words, tags, valid bits) SHALL be a sub-module cache_array with one read port and one full-line write port with synchronous valid clear; cache_controller holds FSM and counters.

Verification
REQ-031 Reset, then read 1024 -> miss, mem_address=1024, data_out=0 after 2+MEM_LATENCY cycles, hit=0, access_count=1, hit_count=0.
REQ-032 Then read 1025, 1026, 1027 -> each hit, data_out=1, 2, 3 two cycles after acceptance, hit_count=3.
REQ-033 Read 5120 (same index 256, tag 1) -> miss, data_out=4096; then read 1024 -> miss again (line evicted), data_out=0.
REQ-034 req_valid held high with address 1030 during a FILL -> req_ready=0, request not accepted until IDLE; then data_out=6.
REQ-035 Assert rst for one cycle in the middle of a FILL for 2048 -> no data_valid; subsequent read 2048 -> miss, data_out=1024.
REQ-036 Build without CACHE_STATS_EN, repeat REQ-031/032 -> identical data timing, hit_count=access_count=0.
